// File: rtl/retire_unit_pkg.sv
// pipTypes: shared types for the commit stage.
//   rob_entry_t    - one reorder-buffer entry as presented at the ROB head window
//   retire_state_t - store-commit state of the retire unit
package pipTypes;

  typedef struct packed {
    logic        dest_reg_valid;
    logic [4:0]  dest_reg;
    logic [31:0] result_lo;
    logic        is_store;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic [3:0]  store_be;
  } rob_entry_t;

  typedef enum logic [0:0] {
    RS_RUN,
    RS_STORE_WAIT
  } retire_state_t;

endpackage

// File: rtl/retire_unit_select.sv
// retire_select: combinational prefix finder for the ROB head window.
//   slot_data_i/slot_valid_i/slot_kill_i - head window, slot 0 oldest
//   empty_i                              - ROB empty
//   n_o                                  - length of the eligible retire prefix
//   we_mask_o                            - register-file write enables for that prefix,
//                                          older same-dest writes suppressed
module retire_select
  import pipTypes::*;
#(
  parameter int unsigned EXT_COUNT    = 4,
  parameter int unsigned EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  rob_entry_t [EXT_COUNT-1:0] slot_data_i,
  input  logic [EXT_COUNT-1:0]       slot_valid_i,
  input  logic [EXT_COUNT-1:0]       slot_kill_i,
  input  logic                       empty_i,
  output logic [EXTCOUNTLOG2:0]      n_o,
  output logic [EXT_COUNT-1:0]       we_mask_o
);

  logic                 stop;
  logic [EXT_COUNT-1:0] in_prefix;
  logic [EXT_COUNT-1:0] we_cand;
  logic                 unused_store_fields;

  // A non-killed store can only retire from slot 0 (via the store handshake),
  // so one found deeper in the window ends the prefix.
  always_comb begin
    stop      = 1'b0;
    n_o       = '0;
    in_prefix = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (!slot_valid_i[i] || empty_i ||
          ((i > 0) && !slot_kill_i[i] && slot_data_i[i].is_store)) begin
        stop = 1'b1;
      end
      if (!stop) begin
        in_prefix[i] = 1'b1;
        n_o          = n_o + 1'b1;
      end
    end
  end

  // Only the youngest write to a given register in the group survives.
  always_comb begin
    we_cand   = '0;
    we_mask_o = '0;
    for (int j = 0; j < EXT_COUNT; j++) begin
      we_cand[j] = in_prefix[j] && !slot_kill_i[j] && slot_data_i[j].dest_reg_valid &&
                   (slot_data_i[j].dest_reg != 5'd0);
    end
    for (int j = 0; j < EXT_COUNT; j++) begin
      we_mask_o[j] = we_cand[j];
      for (int k = j + 1; k < EXT_COUNT; k++) begin
        if (we_cand[k] && (slot_data_i[k].dest_reg == slot_data_i[j].dest_reg)) begin
          we_mask_o[j] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    unused_store_fields = 1'b0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      unused_store_fields = unused_store_fields ^
                            (^{slot_data_i[i].store_addr, slot_data_i[i].store_data,
                               slot_data_i[i].store_be});
    end
  end

endmodule

// File: rtl/retire_unit.sv
// retire_unit: in-order commit stage below the reorder buffer.
//   clock/reset                          - clock, synchronous active-high reset
//   slot_data/slot_valid/slot_kill/empty - ROB head window, slot 0 oldest
//   consume/consume_count                - combinational retire request (count = n-1)
//   rf_we/rf_waddr/rf_wdata              - registered register-file write ports
//   sb_valid/sb_ready/sb_addr/sb_data/sb_be - one-at-a-time store commit handshake
//   retired_total                        - wrapping count of non-killed retirements
// Optional (macro RETIRE_PERF_EN): killed_total, store_stall_cycles counters.
module retire_unit
  import pipTypes::*;
#(
  parameter int unsigned EXT_COUNT    = 4,
  parameter int unsigned EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  rob_entry_t [EXT_COUNT-1:0]    slot_data,
  input  logic [EXT_COUNT-1:0]          slot_valid,
  input  logic [EXT_COUNT-1:0]          slot_kill,
  input  logic                          empty,
  output logic                          consume,
  output logic [EXTCOUNTLOG2-1:0]       consume_count,
  output logic [EXT_COUNT-1:0]          rf_we,
  output logic [EXT_COUNT-1:0][4:0]     rf_waddr,
  output logic [EXT_COUNT-1:0][31:0]    rf_wdata,
  output logic                          sb_valid,
  input  logic                          sb_ready,
  output logic [31:0]                   sb_addr,
  output logic [31:0]                   sb_data,
  output logic [3:0]                    sb_be,
`ifdef RETIRE_PERF_EN
  output logic [31:0]                   killed_total,
  output logic [31:0]                   store_stall_cycles,
`endif
  output logic [31:0]                   retired_total
);

  retire_state_t               state_q, state_d;
  logic [EXTCOUNTLOG2:0]       n_sel, n_m1, live_cnt, killed_cnt;
  logic [EXT_COUNT-1:0]        we_sel;
  logic                        start_store, retire_run, store_done;

  logic [EXT_COUNT-1:0]        rf_we_q, rf_we_d;
  logic [EXT_COUNT-1:0][4:0]   rf_waddr_q, rf_waddr_d;
  logic [EXT_COUNT-1:0][31:0]  rf_wdata_q, rf_wdata_d;
  logic                        sb_valid_q, sb_valid_d;
  logic [31:0]                 sb_addr_q, sb_addr_d, sb_data_q, sb_data_d;
  logic [3:0]                  sb_be_q, sb_be_d;
  logic [31:0]                 retired_total_q, retired_total_d;

  retire_select #(
    .EXT_COUNT    (EXT_COUNT),
    .EXTCOUNTLOG2 (EXTCOUNTLOG2)
  ) u_select (
    .slot_data_i  (slot_data),
    .slot_valid_i (slot_valid),
    .slot_kill_i  (slot_kill),
    .empty_i      (empty),
    .n_o          (n_sel),
    .we_mask_o    (we_sel)
  );

  assign start_store = !empty && slot_valid[0] && !slot_kill[0] && slot_data[0].is_store;
  assign n_m1        = n_sel - 1'b1;

  // FSM next state and retire decision.
  always_comb begin
    state_d       = state_q;
    consume       = 1'b0;
    consume_count = '0;
    retire_run    = 1'b0;
    store_done    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RS_RUN: begin
          if (start_store) begin
            state_d = RS_STORE_WAIT;
          end else if (n_sel != '0) begin
            consume       = 1'b1;
            consume_count = n_m1[EXTCOUNTLOG2-1:0];
            retire_run    = 1'b1;
          end
        end
        RS_STORE_WAIT: begin
          if (sb_ready) begin
            consume    = 1'b1;
            store_done = 1'b1;
            state_d    = RS_RUN;
          end
        end
        default: state_d = RS_RUN;
      endcase
    end
  end

  // Per-group tallies over the retiring prefix.
  always_comb begin
    live_cnt   = '0;
    killed_cnt = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if ((EXTCOUNTLOG2+1)'(i) < n_sel) begin
        if (slot_kill[i]) killed_cnt = killed_cnt + 1'b1;
        else              live_cnt   = live_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rf_we_d    = retire_run ? we_sel : '0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (retire_run && ((EXTCOUNTLOG2+1)'(i) < n_sel)) begin
        rf_waddr_d[i] = slot_data[i].dest_reg;
        rf_wdata_d[i] = slot_data[i].result_lo;
      end
    end

    sb_valid_d = sb_valid_q;
    sb_addr_d  = sb_addr_q;
    sb_data_d  = sb_data_q;
    sb_be_d    = sb_be_q;
    if (state_q == RS_RUN && start_store && !reset) begin
      sb_valid_d = 1'b1;
      sb_addr_d  = slot_data[0].store_addr;
      sb_data_d  = slot_data[0].store_data;
      sb_be_d    = slot_data[0].store_be;
    end else if (store_done) begin
      sb_valid_d = 1'b0;
    end

    retired_total_d = retired_total_q;
    if (retire_run)      retired_total_d = retired_total_q + 32'(live_cnt);
    else if (store_done) retired_total_d = retired_total_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= RS_RUN;
      rf_we_q         <= '0;
      rf_waddr_q      <= '0;
      rf_wdata_q      <= '0;
      sb_valid_q      <= 1'b0;
      sb_addr_q       <= '0;
      sb_data_q       <= '0;
      sb_be_q         <= '0;
      retired_total_q <= '0;
    end else begin
      state_q         <= state_d;
      rf_we_q         <= rf_we_d;
      rf_waddr_q      <= rf_waddr_d;
      rf_wdata_q      <= rf_wdata_d;
      sb_valid_q      <= sb_valid_d;
      sb_addr_q       <= sb_addr_d;
      sb_data_q       <= sb_data_d;
      sb_be_q         <= sb_be_d;
      retired_total_q <= retired_total_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign rf_waddr      = rf_waddr_q;
  assign rf_wdata      = rf_wdata_q;
  assign sb_valid      = sb_valid_q;
  assign sb_addr       = sb_addr_q;
  assign sb_data       = sb_data_q;
  assign sb_be         = sb_be_q;
  assign retired_total = retired_total_q;

`ifdef RETIRE_PERF_EN
  logic [31:0] killed_total_q, killed_total_d;
  logic [31:0] store_stall_q, store_stall_d;

  always_comb begin
    killed_total_d = retire_run ? killed_total_q + 32'(killed_cnt) : killed_total_q;
    store_stall_d  = (state_q == RS_STORE_WAIT && !sb_ready) ? store_stall_q + 32'd1
                                                             : store_stall_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      killed_total_q <= '0;
      store_stall_q  <= '0;
    end else begin
      killed_total_q <= killed_total_d;
      store_stall_q  <= store_stall_d;
    end
  end

  assign killed_total       = killed_total_q;
  assign store_stall_cycles = store_stall_q;
`else
  logic unused_killed_cnt;
  assign unused_killed_cnt = ^killed_cnt;
`endif

endmodule
